multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Parametrised multi-cycle successor to the single-cycle opcode decoder.
- Sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB with req/ack handshakes to instruction and data memory.
- Emits per-state control strobes, a sticky trap on illegal opcode or memory timeout, and a retired-instruction counter.
- Sits between the IR/PC datapath registers and the memories, replacing the combinational decoder in the multi-cycle core.

Parameters:
- ALUOP_W, 4, width of alu_op (>=4)
- TIMEOUT, 16, max wait cycles for any ack; 0 disables timeout
- CNT_W, 32, width of the instret counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  current instruction word from IR (opcode [6:0], func3 [14:12], func7 [31:25])
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory transfer complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- ir_we  out  1  load IR, one-cycle pulse
- pc_we  out  1  update PC, one-cycle pulse
- reg_write  out  1  regfile write strobe
- mem_read  out  1  load qualifier on dmem_req
- mem_write  out  1  store qualifier on dmem_req
- mem_to_reg  out  1  writeback source: 1 = memory, 0 = ALU/link
- alu_src  out  1  ALU operand B: 1 = immediate, 0 = rs2
- branch  out  1  branch-resolve strobe in EXEC
- jump  out  1  jump strobe in EXEC
- alu_op  out  ALUOP_W  0=NOP, 1=ADD, 2=FUNC (func3/func7), 4=SUB, 8=PASSB
- trap  out  1  sticky fault flag
- trap_cause  out  2  1=illegal, 2=imem timeout, 3=dmem timeout
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n low):
  - state=FETCH; all outputs 0; instret=0; trap cleared.
  - Reset mid-handshake drops req immediately; no pulse completes.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - imem_req=1 until imem_ack.
  - Ack cycle: ir_we=1, next state DECODE.
- DECODE:
  - Registers the decoded class and alu_op/alu_src/mem_to_reg; these hold stable through the end of the instruction.
  - Unknown opcode -> TRAP, cause 1.
- EXEC (1 cycle):
  - branch=1 for BRANCH (alu_op=SUB).
  - jump=1 for JAL.
- Paths and pc_we timing:
  - R/I-ALU (alu_op=FUNC): EXEC -> WB.
  - Load/store (alu_op=ADD): EXEC -> MEM.
  - JAL: EXEC -> WB.
  - Branch: pc_we=1 in EXEC, then FETCH.
- MEM:
  - dmem_req=1 plus mem_read (load) or mem_write (store) until dmem_ack.
  - Load -> WB.
  - Store: pc_we=1 in ack cycle, then FETCH.
- WB (1 cycle): reg_write=1, pc_we=1, then FETCH.
- Latency excluding waits: ALU 4, load 5, store 4, branch 3, JAL 4 cycles.
- instret increments in every cycle pc_we=1; wraps modulo 2^CNT_W.
- Timeout:
  - Counter cleared on entering FETCH/MEM; counts each cycle req is high without ack.
  - Reaching TIMEOUT -> TRAP, cause 2 or 3.
  - Ack in the same cycle the limit is reached: ack wins.
  - TIMEOUT=0: wait indefinitely.
- TRAP: all strobes 0; trap=1 and trap_cause held until reset; instret frozen.
- Rules:
  - Outputs are registered (state-decoded from registered state); no combinational path from ack to req.
  - dmem_req is never asserted together with imem_req.
  - mem_read and mem_write are never both 1.

Optional Feature:
- Macro: CTRL_EXT_OPCODES_EN.
- Defined:
  - Adds LUI (0110111): alu_op=PASSB, alu_src=1, path EXEC -> WB.
  - Adds AUIPC (0010111): alu_op=ADD, alu_src=1, path EXEC -> WB.
  - Adds JALR (1100111): jump=1, alu_op=ADD, alu_src=1, path EXEC -> WB.
- Undefined: these three opcodes trap with cause 1.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams;
  - the state enum;
  - alu_op codes (NOP/ADD/FUNC/SUB/PASSB);
  - trap_cause codes;
  - the instruction-class enum.
- Sub-module ctrl_timeout_cnt: load/clear/count/expire, width $clog2(TIMEOUT+1).
- FSM and decode stay in the top module.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), imem_ack after 2 wait cycles -> imem_req high 3 cycles; ir_we; EXEC alu_op=2, alu_src=0; WB reg_write=1, pc_we=1; instret 0->1.
- LW (0x0000A183), dmem_ack after 1 wait -> MEM: dmem_req=mem_read=1 for 2 cycles; WB: mem_to_reg=1, reg_write=1.
- SW (0x0020A023) -> mem_write=1, reg_write never 1; pc_we in dmem_ack cycle; 4 cycles with zero wait.
- Opcode 0x7F -> trap=1, cause=1 after DECODE; stays through 20 more cycles; instret unchanged.
- TIMEOUT=4, imem_ack held low -> trap cause 2 after 4 req cycles; repeat with ack on cycle 4 -> no trap.
- rst_n low during MEM of a load -> dmem_req drops same cycle; after release, FETCH with imem_req=1 and instret=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: opcodes, states,
// ALU operation codes, trap causes and instruction classes.
package ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_NOP   = 4'd0;
  localparam logic [3:0] ALU_ADD   = 4'd1;
  localparam logic [3:0] ALU_FUNC  = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd4;
  localparam logic [3:0] ALU_PASSB = 4'd8;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE, CAUSE_ILLEGAL, CAUSE_IMEM_TIMEOUT, CAUSE_DMEM_TIMEOUT
  } trap_cause_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP
  } instr_class_e;

  typedef struct packed {
    instr_class_e cls;
    logic [3:0]   alu_op;
    logic         alu_src;
    logic         mem_to_reg;
  } ctrl_dec_t;

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// Handshake watchdog: counts cycles a request waits without ack and flags
// expiry on the wait cycle that reaches TIMEOUT. TIMEOUT=0 never expires.
module ctrl_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign expire = 1'b0;
    end else begin : g_enabled
      localparam int unsigned W = $clog2(TIMEOUT + 1);
      logic [W-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt <= '0;
        else if (clear) cnt <= '0;
        else if (count) cnt <= cnt + 1'b1;
      end

      // The limit is hit during the TIMEOUT-th waiting cycle; an ack in that
      // cycle deasserts count, so the ack wins.
      assign expire = count && (cnt == W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with memory
// handshakes, sticky trap and instret. Define CTRL_EXT_OPCODES_EN for LUI/AUIPC/JALR.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               ir_we,
  output logic               pc_we,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               alu_src,
  output logic               branch,
  output logic               jump,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [CNT_W-1:0]   instret
);

  function automatic ctrl_dec_t decode(input logic [6:0] opc);
    ctrl_dec_t d;
    d = '{cls: CLS_ILLEGAL, alu_op: ALU_NOP, alu_src: 1'b0, mem_to_reg: 1'b0};
    case (opc)
      OPC_OP:     begin d.cls = CLS_ALU;    d.alu_op = ALU_FUNC;                  end
      OPC_OP_IMM: begin d.cls = CLS_ALU;    d.alu_op = ALU_FUNC; d.alu_src = 1'b1; end
      OPC_LOAD:   begin d.cls = CLS_LOAD;   d.alu_op = ALU_ADD;  d.alu_src = 1'b1;
                        d.mem_to_reg = 1'b1;                                        end
      OPC_STORE:  begin d.cls = CLS_STORE;  d.alu_op = ALU_ADD;  d.alu_src = 1'b1; end
      OPC_BRANCH: begin d.cls = CLS_BRANCH; d.alu_op = ALU_SUB;                   end
      OPC_JAL:    begin d.cls = CLS_JUMP;                                          end
`ifdef CTRL_EXT_OPCODES_EN
      OPC_LUI:    begin d.cls = CLS_ALU;  d.alu_op = ALU_PASSB; d.alu_src = 1'b1; end
      OPC_AUIPC:  begin d.cls = CLS_ALU;  d.alu_op = ALU_ADD;   d.alu_src = 1'b1; end
      OPC_JALR:   begin d.cls = CLS_JUMP; d.alu_op = ALU_ADD;   d.alu_src = 1'b1; end
`endif
      default: ;
    endcase
    return d;
  endfunction

  state_e      state, state_next;
  trap_cause_e cause_q, cause_next;
  ctrl_dec_t   dec, ctrl_q;
  logic        run;
  logic        tmo_clear, tmo_count, tmo_expire;
  logic        unused_instr_bits;

  // func3/func7 are consumed by the ALU through alu_op=FUNC, not by the FSM.
  assign unused_instr_bits = ^instr[31:7];
  assign dec = decode(instr[6:0]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_FETCH;
      run     <= 1'b0;
      cause_q <= CAUSE_NONE;
      ctrl_q  <= '0;
    end else begin
      state   <= state_next;
      run     <= 1'b1;
      cause_q <= cause_next;
      if (state_next == ST_TRAP)  ctrl_q <= '0;
      else if (state == ST_DECODE) ctrl_q <= dec;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause_q;
    case (state)
      ST_FETCH: begin
        if (imem_req && imem_ack) state_next = ST_DECODE;
        else if (tmo_expire) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_IMEM_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (dec.cls == CLS_ILLEGAL) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (ctrl_q.cls)
          CLS_LOAD, CLS_STORE: state_next = ST_MEM;
          CLS_BRANCH:          state_next = ST_FETCH;
          default:             state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) state_next = (ctrl_q.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        else if (tmo_expire) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_DMEM_TIMEOUT;
        end
      end
      ST_WB:   state_next = ST_FETCH;
      ST_TRAP: state_next = ST_TRAP;
      default: state_next = ST_FETCH;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    case (state)
      ST_FETCH: begin
        // run masks the first cycle out of reset so reset leaves all outputs low.
        imem_req = run;
        ir_we    = run && imem_ack;
      end
      ST_EXEC: begin
        branch = (ctrl_q.cls == CLS_BRANCH);
        jump   = (ctrl_q.cls == CLS_JUMP);
        pc_we  = (ctrl_q.cls == CLS_BRANCH);
      end
      ST_MEM: begin
        dmem_req  = 1'b1;
        mem_read  = (ctrl_q.cls == CLS_LOAD);
        mem_write = (ctrl_q.cls == CLS_STORE);
        pc_we     = (ctrl_q.cls == CLS_STORE) && dmem_ack;
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_we     = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_op     = ALUOP_W'(ctrl_q.alu_op);
  assign alu_src    = ctrl_q.alu_src;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign trap       = (state == ST_TRAP);
  assign trap_cause = cause_q;

  assign tmo_count = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
  assign tmo_clear = (state_next != state) &&
                     ((state_next == ST_FETCH) || (state_next == ST_MEM));

  ctrl_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmo_clear),
    .count  (tmo_count),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     instret <= '0;
    else if (pc_we) instret <= instret + 1'b1;
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: table-driven instruction vectors
// through a scoreboard, plus trap, timeout and mid-handshake reset sequences.
module tb_multicycle_ctrl_fsm;

  localparam int ALUOP_W = 4;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int NEVER   = 1000;

  logic               clk, rst_n;
  logic [31:0]        instr;
  logic               imem_ack, dmem_ack;
  logic               imem_req, dmem_req, ir_we, pc_we, reg_write;
  logic               mem_read, mem_write, mem_to_reg, alu_src, branch, jump;
  logic [ALUOP_W-1:0] alu_op;
  logic               trap;
  logic [1:0]         trap_cause;
  logic [CNT_W-1:0]   instret;

  multicycle_ctrl_fsm #(.ALUOP_W(ALUOP_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_we(ir_we), .pc_we(pc_we),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .branch(branch), .jump(jump),
    .alu_op(alu_op), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          iw;
    int          dw;
    logic [3:0]  alu_op;
    logic        alu_src, m2r, br, jmp, rw, mr, mw;
    int          cycles;
    int          dreq;
  } vec_t;

  typedef struct {
    vec_t             v;
    logic [CNT_W-1:0] instret;
  } exp_t;

  vec_t             vecs[$];
  exp_t             sb_q[$];
  logic [CNT_W-1:0] model_instret;
  int               n_cmp = 0;
  int               n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    check("reset_strobes", {imem_req, dmem_req, ir_we, pc_we, reg_write, mem_read,
                            mem_write, mem_to_reg, alu_src, branch, jump, trap}, 0);
    check("reset_regs", {alu_op, trap_cause, instret}, 0);
    model_instret = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input vec_t v);
    exp_t e;
    int   req_i = 0, req_d = 0, cycles = 0, irwe = 0;
    bit   done = 0, br = 0, jmp = 0, rw = 0, mr = 0, mw = 0, excl_ok = 1;
    instr = v.instr;
    sb_q.push_back('{v: v, instret: model_instret});
    model_instret = model_instret + 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      imem_ack = imem_req && (req_i == v.iw);
      dmem_ack = dmem_req && (req_d == v.dw);
      #1;
      if (imem_req) req_i++;
      if (dmem_req) req_d++;
      if (imem_req || cycles > 0) cycles++;
      if (ir_we) irwe++;
      br  |= branch;
      jmp |= jump;
      rw  |= reg_write;
      mr  |= mem_read;
      mw  |= mem_write;
      if ((imem_req && dmem_req) || (mem_read && mem_write)) excl_ok = 0;
      if (pc_we) begin
        done = 1;
        e = sb_q.pop_front();
        check({e.v.name, "_cycles"}, cycles, e.v.cycles);
        check({e.v.name, "_imem_req_cycles"}, req_i, e.v.iw + 1);
        check({e.v.name, "_dmem_req_cycles"}, req_d, e.v.dreq);
        check({e.v.name, "_ir_we"}, irwe, 1);
        check({e.v.name, "_alu_op"}, alu_op, e.v.alu_op);
        check({e.v.name, "_alu_src"}, alu_src, e.v.alu_src);
        check({e.v.name, "_mem_to_reg"}, mem_to_reg, e.v.m2r);
        check({e.v.name, "_br_jmp"}, {br, jmp}, {e.v.br, e.v.jmp});
        check({e.v.name, "_rw_mr_mw"}, {rw, mr, mw}, {e.v.rw, e.v.mr, e.v.mw});
        check({e.v.name, "_exclusive"}, excl_ok, 1);
        check({e.v.name, "_instret"}, instret, e.instret);
      end
    end
    if (!done) begin
      check({v.name, "_retire_timeout"}, 0, 1);
      void'(sb_q.pop_back());
    end
  endtask

  task automatic run_trap(input string name, input logic [31:0] ins, input int iw,
                          input int dw, input logic [1:0] cause, input int exp_ireq,
                          input int exp_dreq, input int exp_cyc);
    int req_i = 0, req_d = 0, cycles = 0;
    bit seen = 0, held = 1, quiet = 1, frozen = 1;
    instr = ins;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      imem_ack = imem_req && (req_i == iw);
      dmem_ack = dmem_req && (req_d == dw);
      #1;
      if (imem_req) req_i++;
      if (dmem_req) req_d++;
      if (imem_req || cycles > 0) cycles++;
      if (trap) seen = 1;
    end
    check({name, "_trap_seen"}, seen, 1);
    check({name, "_cause"}, trap_cause, cause);
    check({name, "_imem_req_cycles"}, req_i, exp_ireq);
    check({name, "_dmem_req_cycles"}, req_d, exp_dreq);
    check({name, "_cycles"}, cycles, exp_cyc);
    check({name, "_instret"}, instret, model_instret);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      #1;
      if (!trap || trap_cause !== cause) held = 0;
      if ({imem_req, dmem_req, ir_we, pc_we, reg_write, mem_read, mem_write,
           branch, jump} !== '0) quiet = 0;
      if (instret !== model_instret) frozen = 0;
    end
    check({name, "_trap_held"}, held, 1);
    check({name, "_trap_quiet"}, quiet, 1);
    check({name, "_instret_frozen"}, frozen, 1);
  endtask

  task automatic reset_mid_mem();
    int  req_d = 0;
    bit  seen = 0;
    instr = 32'h0000A183;
    for (int c = 0; c < 20 && req_d < 2; c++) begin
      @(negedge clk);
      imem_ack = imem_req;
      dmem_ack = 1'b0;
      #1;
      if (dmem_req) req_d++;
    end
    check("rstmem_reached_mem", req_d, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmem_req_drop", {dmem_req, mem_read, imem_req, pc_we}, 0);
    check("rstmem_instret_clear", instret, 0);
    model_instret = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      #1;
      if (imem_req) seen = 1;
    end
    check("rstmem_fetch_req", seen, 1);
    check("rstmem_fetch_instret", instret, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    instr = '0;
    model_instret = '0;

    vecs.push_back('{"add",      32'h002081B3, 2, 0,     4'd2, 0, 0, 0, 0, 1, 0, 0, 6, 0});
    vecs.push_back('{"lw",       32'h0000A183, 0, 1,     4'd1, 1, 1, 0, 0, 1, 1, 0, 6, 2});
    vecs.push_back('{"sw",       32'h0020A023, 0, 0,     4'd1, 1, 0, 0, 0, 0, 0, 1, 4, 1});
    vecs.push_back('{"addi",     32'h00108093, 0, 0,     4'd2, 1, 0, 0, 0, 1, 0, 0, 4, 0});
    vecs.push_back('{"beq",      32'h00208463, 1, 0,     4'd4, 0, 0, 1, 0, 0, 0, 0, 4, 0});
    vecs.push_back('{"jal",      32'h008000EF, 0, 0,     4'd0, 0, 0, 0, 1, 1, 0, 0, 4, 0});
    vecs.push_back('{"sub_slow", 32'h402081B3, 3, 0,     4'd2, 0, 0, 0, 0, 1, 0, 0, 7, 0});
    vecs.push_back('{"lw_slow",  32'h0000A183, 2, 3,     4'd1, 1, 1, 0, 0, 1, 1, 0, 10, 4});
    vecs.push_back('{"sw_slow",  32'h0020A023, 0, 3,     4'd1, 1, 0, 0, 0, 0, 0, 1, 7, 4});
`ifdef CTRL_EXT_OPCODES_EN
    vecs.push_back('{"lui",      32'h000010B7, 0, 0,     4'd8, 1, 0, 0, 0, 1, 0, 0, 4, 0});
    vecs.push_back('{"auipc",    32'h00001097, 0, 0,     4'd1, 1, 0, 0, 0, 1, 0, 0, 4, 0});
    vecs.push_back('{"jalr",     32'h000080E7, 0, 0,     4'd1, 1, 0, 0, 1, 1, 0, 0, 4, 0});
`endif

    do_reset();
    // Two passes so the narrow instret wraps past its maximum.
    for (int pass = 0; pass < 2; pass++)
      foreach (vecs[i]) run_instr(vecs[i]);

    run_trap("illegal_7f", 32'h0000007F, 0, NEVER, 2'd1, 1, 0, 3);
`ifndef CTRL_EXT_OPCODES_EN
    do_reset();
    run_trap("lui_illegal", 32'h000010B7, 0, NEVER, 2'd1, 1, 0, 3);
`endif
    do_reset();
    run_trap("imem_timeout", 32'h002081B3, NEVER, NEVER, 2'd2, 4, 0, 5);
    do_reset();
    run_trap("dmem_timeout", 32'h0000A183, 0, NEVER, 2'd3, 1, 4, 8);

    do_reset();
    run_instr(vecs[3]);
    reset_mid_mem();

    check("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
